// File: rtl/avr_fetch_ctrl.sv
// Instruction fetch sequencer for avr_cpu: owns the PC, reads program memory over a
// req/ack port and presents assembled one- or two-word instructions to the core.
module avr_fetch_ctrl #(
    parameter int              PC_W    = 16,
    parameter logic [PC_W-1:0] RST_VEC = '0
) (
    input  logic            CLK,
    input  logic            RST,
    output logic [PC_W-1:0] pm_addr,
    output logic            pm_req,
    input  logic            pm_ack,
    input  logic [15:0]     pm_data,
    output logic [15:0]     instr,
    output logic [15:0]     instr2,
    output logic            instr_valid,
    output logic [PC_W-1:0] instr_pc,
    input  logic            stall,
    input  logic            skip,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc
);

    typedef enum logic [1:0] {
        FETCH1 = 2'd0,
        FETCH2 = 2'd1,
        ISSUE  = 2'd2
    } state_e;

    localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);
    localparam logic [PC_W-1:0] PC_TWO = PC_W'(2);

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            skip_pend_q, skip_pend_d;
    logic            pm_req_q, pm_req_d;
    logic [15:0]     w1_q, w1_d;
    logic [15:0]     instr_q, instr_d;
    logic [15:0]     instr2_q, instr2_d;
    logic            instr_valid_q, instr_valid_d;
    logic [PC_W-1:0] instr_pc_q, instr_pc_d;
    logic            fetch_ack;

    function automatic logic is_two_word(input logic [15:0] w);
        return ((w & 16'hFC0F) == 16'h9000) || ((w & 16'hFE0C) == 16'h940C);
    endfunction

    // An ack only counts while our request is actually visible on the port.
    assign fetch_ack = pm_req_q & pm_ack;

    always_comb begin
        // NOTE: every _d defaults to its _q so no path through this block infers a latch.
        state_d       = state_q;
        pc_d          = pc_q;
        skip_pend_d   = skip_pend_q;
        w1_d          = w1_q;
        instr_d       = instr_q;
        instr2_d      = instr2_q;
        instr_valid_d = instr_valid_q;
        instr_pc_d    = instr_pc_q;

        case (state_q)
            FETCH1: begin
                if (fetch_ack) begin
                    pc_d = pc_q + PC_ONE;
                    if (skip_pend_q) begin
                        // Discard this instruction; a two-word one also jumps its operand word.
                        skip_pend_d = 1'b0;
                        if (is_two_word(pm_data)) pc_d = pc_q + PC_TWO;
                    end else if (is_two_word(pm_data)) begin
                        w1_d       = pm_data;
                        instr_pc_d = pc_q;
                        state_d    = FETCH2;
                    end else begin
                        instr_d       = pm_data;
                        instr2_d      = 16'h0000;
                        instr_pc_d    = pc_q;
                        instr_valid_d = 1'b1;
                        state_d       = ISSUE;
                    end
                end
            end
            FETCH2: begin
                if (fetch_ack) begin
                    instr_d       = w1_q;
                    instr2_d      = pm_data;
                    pc_d          = pc_q + PC_ONE;
                    instr_valid_d = 1'b1;
                    state_d       = ISSUE;
                end
            end
            ISSUE: begin
                if (!stall) begin
                    skip_pend_d   = skip;
                    instr_d       = 16'h0000;
                    instr2_d      = 16'h0000;
                    instr_valid_d = 1'b0;
                    state_d       = FETCH1;
                end
            end
            default: state_d = FETCH1;
        endcase

        if (redirect) begin
            pc_d          = redirect_pc;
            state_d       = FETCH1;
            skip_pend_d   = 1'b0;
            instr_d       = 16'h0000;
            instr2_d      = 16'h0000;
            instr_valid_d = 1'b0;
        end

        // Registered request: low through reset, raised on the first edge after release.
        pm_req_d = (state_d != ISSUE);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q       <= FETCH1;
            pc_q          <= RST_VEC;
            skip_pend_q   <= 1'b0;
            pm_req_q      <= 1'b0;
            w1_q          <= 16'h0000;
            instr_q       <= 16'h0000;
            instr2_q      <= 16'h0000;
            instr_valid_q <= 1'b0;
            instr_pc_q    <= RST_VEC;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            skip_pend_q   <= skip_pend_d;
            pm_req_q      <= pm_req_d;
            w1_q          <= w1_d;
            instr_q       <= instr_d;
            instr2_q      <= instr2_d;
            instr_valid_q <= instr_valid_d;
            instr_pc_q    <= instr_pc_d;
        end
    end

    assign pm_addr     = pc_q;
    assign pm_req      = pm_req_q;
    assign instr       = instr_q;
    assign instr2      = instr2_q;
    assign instr_valid = instr_valid_q;
    assign instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_avr_fetch_ctrl.sv
// Self-checking bench for avr_fetch_ctrl: directed scenarios with zero-wait memory,
// then randomized handshake/stall/skip/redirect traffic against a program-order model.
module tb_avr_fetch_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic [15:0] pm_addr, pm_data, instr, instr2, instr_pc, redirect_pc;
    logic        pm_req, pm_ack, instr_valid, stall, skip, redirect;

    logic        rst_w;
    logic [15:0] w_pm_addr, w_pm_data, w_instr, w_instr2, w_instr_pc;
    logic        w_pm_req, w_instr_valid;
    logic        w_ack = 1'b1;
    logic        w_zero = 1'b0;
    logic [15:0] w_rpc = 16'h0000;

    logic [15:0] mem [0:65535];

    int n_checks = 0;
    int n_pass   = 0;

    assign pm_data   = mem[pm_addr];
    assign w_pm_data = mem[w_pm_addr];

    always #5 CLK = ~CLK;

    avr_fetch_ctrl #(.PC_W(16), .RST_VEC(16'h0000)) dut (
        .CLK(CLK), .RST(RST), .pm_addr(pm_addr), .pm_req(pm_req), .pm_ack(pm_ack),
        .pm_data(pm_data), .instr(instr), .instr2(instr2), .instr_valid(instr_valid),
        .instr_pc(instr_pc), .stall(stall), .skip(skip), .redirect(redirect),
        .redirect_pc(redirect_pc)
    );

    avr_fetch_ctrl #(.PC_W(16), .RST_VEC(16'hFFFF)) dut_w (
        .CLK(CLK), .RST(rst_w), .pm_addr(w_pm_addr), .pm_req(w_pm_req), .pm_ack(w_ack),
        .pm_data(w_pm_data), .instr(w_instr), .instr2(w_instr2), .instr_valid(w_instr_valid),
        .instr_pc(w_instr_pc), .stall(w_zero), .skip(w_zero), .redirect(w_zero),
        .redirect_pc(w_rpc)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    function automatic logic tb_two(input logic [15:0] w);
        return ((w & 16'hFC0F) == 16'h9000) || ((w & 16'hFE0C) == 16'h940C);
    endfunction

    function automatic logic [15:0] ilen(input logic [15:0] w);
        return tb_two(w) ? 16'd2 : 16'd1;
    endfunction

    task automatic expect_fetch(input string tag, input logic [15:0] addr);
        check({tag, ".req"},   32'(pm_req), 1);
        check({tag, ".addr"},  32'(pm_addr), 32'(addr));
        check({tag, ".valid"}, 32'(instr_valid), 0);
        check({tag, ".instr"}, 32'(instr), 0);
    endtask

    task automatic expect_issue(input string tag, input logic [15:0] pc,
                                input logic [15:0] w1, input logic [15:0] w2);
        check({tag, ".valid"},  32'(instr_valid), 1);
        check({tag, ".req"},    32'(pm_req), 0);
        check({tag, ".pc"},     32'(instr_pc), 32'(pc));
        check({tag, ".instr"},  32'(instr), 32'(w1));
        check({tag, ".instr2"}, 32'(instr2), 32'(w2));
    endtask

    task automatic expect_reset(input string tag);
        check({tag, ".req"},    32'(pm_req), 0);
        check({tag, ".addr"},   32'(pm_addr), 0);
        check({tag, ".instr"},  32'(instr), 0);
        check({tag, ".instr2"}, 32'(instr2), 0);
        check({tag, ".valid"},  32'(instr_valid), 0);
        check({tag, ".pc"},     32'(instr_pc), 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] exp_pc, exp_a, exp_w1, exp_w2, prev_addr, a, w;
        bit          exp_skip, have_exp, prev_hold;
        int          idle;

        RST = 1'b1; rst_w = 1'b1; pm_ack = 1'b1;
        stall = 1'b0; skip = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        mem[0] = 16'hE0A4; mem[1] = 16'h50A1; mem[2] = 16'h0000; mem[3] = 16'h940C;
        mem[4] = 16'h0010; mem[5] = 16'hE0A4; mem[6] = 16'hE0A4; mem[7] = 16'h9000;
        mem[8] = 16'h1234; mem[9] = 16'h50A1; mem[16'h10] = 16'hE0B5;
        mem[16'h20] = 16'hE0C6; mem[16'hFFFF] = 16'hE0D7;

        // Reset held two cycles with ack high, then straight-line fetch
        tick(); tick();
        expect_reset("rst");
        RST = 1'b0;
        tick(); expect_fetch("c0", 16'd0);
        tick(); expect_issue("c1", 16'd0, 16'hE0A4, 16'h0000);
        tick(); expect_fetch("c2", 16'd1);
        tick(); expect_issue("c3", 16'd1, 16'h50A1, 16'h0000);
        tick(); expect_fetch("c4", 16'd2);
        tick(); expect_issue("c5", 16'd2, 16'h0000, 16'h0000);

        // Two-word JMP, then redirect on the following instruction
        tick(); expect_fetch("jmp.w1", 16'd3);
        tick(); expect_fetch("jmp.w2", 16'd4);
        tick(); expect_issue("jmp", 16'd3, 16'h940C, 16'h0010);
        tick(); expect_fetch("after_jmp", 16'd5);
        tick(); expect_issue("i5", 16'd5, 16'hE0A4, 16'h0000);
        redirect = 1'b1; redirect_pc = 16'h0010;
        tick(); redirect = 1'b0;
        expect_fetch("redir10", 16'h0010);

        // Wait states, then a long stall in ISSUE
        pm_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); expect_fetch("wait", 16'h0010);
        end
        pm_ack = 1'b1;
        tick(); expect_issue("post_wait", 16'h0010, 16'hE0B5, 16'h0000);
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(); expect_issue("stall", 16'h0010, 16'hE0B5, 16'h0000);
        end
        stall = 1'b0;
        tick(); expect_fetch("post_stall", 16'h0011);

        // Skip over a two-word LDS, then over a one-word instruction
        redirect = 1'b1; redirect_pc = 16'd6;
        tick(); redirect = 1'b0;
        expect_fetch("sk1.f6", 16'd6);
        tick(); expect_issue("sk1.i6", 16'd6, 16'hE0A4, 16'h0000);
        skip = 1'b1;
        tick(); skip = 1'b0;
        expect_fetch("sk1.f7", 16'd7);
        tick(); expect_fetch("sk1.f9", 16'd9);
        tick(); expect_issue("sk1.i9", 16'd9, 16'h50A1, 16'h0000);
        mem[7] = 16'h50A1;
        redirect = 1'b1; redirect_pc = 16'd6;
        tick(); redirect = 1'b0;
        expect_fetch("sk2.f6", 16'd6);
        tick(); expect_issue("sk2.i6", 16'd6, 16'hE0A4, 16'h0000);
        skip = 1'b1;
        tick(); skip = 1'b0;
        expect_fetch("sk2.f7", 16'd7);
        tick(); expect_fetch("sk2.f8", 16'd8);
        tick(); expect_issue("sk2.i8", 16'd8, 16'h1234, 16'h0000);

        // Redirect colliding with an ack, then with consume+skip
        tick(); expect_fetch("col.f9", 16'd9);
        redirect = 1'b1; redirect_pc = 16'h0020;
        tick(); redirect = 1'b0;
        expect_fetch("col.f20", 16'h0020);
        tick(); expect_issue("col.i20", 16'h0020, 16'hE0C6, 16'h0000);
        skip = 1'b1; redirect = 1'b1; redirect_pc = 16'd6;
        tick(); skip = 1'b0; redirect = 1'b0;
        expect_fetch("noskip.f6", 16'd6);
        tick(); expect_issue("noskip.i6", 16'd6, 16'hE0A4, 16'h0000);

        // Reset asserted while fetching word 2
        redirect = 1'b1; redirect_pc = 16'd3;
        tick(); redirect = 1'b0;
        expect_fetch("r2.f3", 16'd3);
        tick(); expect_fetch("r2.f4", 16'd4);
        RST = 1'b1;
        #1 expect_reset("r2.async");
        tick(); expect_reset("r2.held");
        RST = 1'b0;
        tick(); expect_fetch("r2.f0", 16'd0);
        tick(); expect_issue("r2.i0", 16'd0, 16'hE0A4, 16'h0000);

        // PC wrap from a reset vector of FFFF
        check("wrap.rst.addr", 32'(w_pm_addr), 32'h0000FFFF);
        check("wrap.rst.pc",   32'(w_instr_pc), 32'h0000FFFF);
        check("wrap.rst.req",  32'(w_pm_req), 0);
        rst_w = 1'b0;
        tick();
        check("wrap.f.req",  32'(w_pm_req), 1);
        check("wrap.f.addr", 32'(w_pm_addr), 32'h0000FFFF);
        tick();
        check("wrap.i.valid", 32'(w_instr_valid), 1);
        check("wrap.i.pc",    32'(w_instr_pc), 32'h0000FFFF);
        check("wrap.i.instr", 32'(w_instr), 32'h0000E0D7);
        tick();
        check("wrap.f0.addr", 32'(w_pm_addr), 0);
        check("wrap.f0.req",  32'(w_pm_req), 1);
        tick();
        check("wrap.i0.pc",    32'(w_instr_pc), 0);
        check("wrap.i0.instr", 32'(w_instr), 32'h0000E0A4);
        rst_w = 1'b1;

        // Randomized traffic against the program-order model
        RST = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            case ($urandom_range(0, 5))
                0:       w = 16'h9000 | (16'($urandom) & 16'h03F0);
                1:       w = 16'h940C | (16'($urandom) & 16'h01F3);
                default: w = 16'($urandom);
            endcase
            mem[i] = w;
        end
        tick();
        RST = 1'b0;
        exp_pc = 16'h0000; exp_skip = 1'b0; have_exp = 1'b0;
        exp_a = 16'h0000; exp_w1 = 16'h0000; exp_w2 = 16'h0000;
        prev_hold = 1'b0; prev_addr = 16'h0000; idle = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (prev_hold) begin
                check("rnd.hold.req",  32'(pm_req), 1);
                check("rnd.hold.addr", 32'(pm_addr), 32'(prev_addr));
            end
            if (instr_valid) begin
                if (!have_exp) begin
                    a = exp_pc;
                    if (exp_skip) a = a + ilen(mem[a]);
                    exp_a  = a;
                    exp_w1 = mem[a];
                    a      = a + 16'd1;
                    exp_w2 = tb_two(exp_w1) ? mem[a] : 16'h0000;
                    have_exp = 1'b1;
                end
                check("rnd.pc",     32'(instr_pc), 32'(exp_a));
                check("rnd.instr",  32'(instr), 32'(exp_w1));
                check("rnd.instr2", 32'(instr2), 32'(exp_w2));
                idle = 0;
            end else begin
                check("rnd.idle_instr", 32'(instr), 0);
                idle++;
                if (idle > 100) begin
                    check("rnd.liveness", 32'(idle), 0);
                    break;
                end
            end

            redirect    = ($urandom_range(0, 15) == 0);
            redirect_pc = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFF0, 16'hFFFF))
                                                      : 16'($urandom);
            stall       = ($urandom_range(0, 2) == 0);
            skip        = ($urandom_range(0, 3) == 0);
            pm_ack      = ($urandom_range(0, 2) != 0);

            prev_hold = pm_req && !pm_ack && !redirect;
            prev_addr = pm_addr;
            if (redirect) begin
                exp_pc = redirect_pc; exp_skip = 1'b0; have_exp = 1'b0; idle = 0;
            end else if (instr_valid && !stall) begin
                exp_pc = exp_a + ilen(exp_w1); exp_skip = skip; have_exp = 1'b0;
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/avr_fetch_ctrl.md
Name: avr_fetch_ctrl

Overview:
Instruction fetch sequencer for avr_cpu. It owns the program counter and drives a handshaked program-memory read port. It assembles one- and two-word AVR instructions and presents them on the core's instr input, holding them while the core stalls. It also handles branch redirects and the skip-next-instruction semantics of CPSE/SBRC/SBRS/SBIC/SBIS.

Parameters:
PC_W, 16, program-counter width in 16-bit words; the PC wraps modulo 2^PC_W.
RST_VEC, 0, word address fetched first after reset.

Ports:
CLK  in  1  clock; all state updates on the rising edge.
RST  in  1  reset, asynchronous, active-high.
pm_addr  out  PC_W  program-memory word address.
pm_req  out  1  read request; pm_addr is stable while pm_req=1 and pm_ack=0.
pm_ack  in  1  read complete; pm_data is valid in the same cycle. May be tied high (zero wait states).
pm_data  in  16  program-memory read data.
instr  out  16  instruction word 1 to the core; 16'h0000 (NOP) whenever instr_valid=0.
instr2  out  16  instruction word 2 (LDS/STS address, JMP/CALL target); 16'h0000 for one-word instructions.
instr_valid  out  1  instr/instr2 hold a real instruction.
instr_pc  out  PC_W  word address of instr.
stall  in  1  core cannot consume this cycle.
skip  in  1  qualified by consume: the next instruction in program order is discarded.
redirect  in  1  load a new PC (jump, branch, call, ret, interrupt).
redirect_pc  in  PC_W  new PC.

Behaviour:
- Consume: instr_valid=1 and stall=0 in the same cycle.
- Two-word decode on word 1:
  - (w & 16'hFC0F) == 16'h9000 is LDS/STS.
  - (w & 16'hFE0C) == 16'h940C is JMP/CALL.
  - All other words are one-word instructions.
- Reset (RST=1, asynchronous):
  - pc=RST_VEC, state=FETCH1, skip_pend=0.
  - pm_req=0, pm_addr=RST_VEC.
  - instr=0, instr2=0, instr_valid=0, instr_pc=RST_VEC.
  - pm_req rises in the first cycle after RST falls.
  - Reset mid-fetch abandons the request; an in-flight pm_ack is ignored.
- State FETCH1: pm_req=1, pm_addr=pc. On pm_ack, latch w1 and set pc<=pc+1, then:
  - skip_pend=1 and w1 one-word: clear skip_pend, stay in FETCH1 (next fetch at pc+1).
  - skip_pend=1 and w1 two-word: clear skip_pend, set pc<=pc+2 without fetching word 2, stay in FETCH1.
  - skip_pend=0 and w1 two-word: go to FETCH2.
  - skip_pend=0 and w1 one-word: go to ISSUE with instr=w1, instr2=0, instr_pc=old pc.
- State FETCH2: pm_req=1, pm_addr=pc. On pm_ack, instr2<=pm_data, pc<=pc+1, go to ISSUE. instr_pc is the address of word 1.
- State ISSUE: pm_req=0, instr_valid=1.
  - instr/instr2/instr_pc hold stable for any number of stall cycles.
  - On consume: skip_pend<=skip, and the next cycle is FETCH1 with instr_valid=0.
- Throughput with pm_ack tied high:
  - One-word instruction: 2 cycles (fetch, issue).
  - Two-word instruction: 3 cycles.
  - No prefetch overlap.
- Wait states: pm_req and pm_addr are held; instr_valid=0 and instr=0000 throughout.
- Redirect has the highest priority, in any state:
  - Next cycle: pc<=redirect_pc, state=FETCH1, skip_pend=0, instr_valid=0, instr=0, instr2=0.
  - A pm_ack in the redirect cycle is discarded.
  - Redirect in the same cycle as consume with skip=1: redirect wins and the skip is dropped.
  - Redirect during stall: redirect wins.
- PC arithmetic: pc+1 and pc+2 wrap modulo 2^PC_W (for example 16'hFFFF+1 = 0). Fetch continues across the wrap.
- No X on any output after reset. pm_addr always equals pc.

Test Plan:
1. Reset: RST=1 for 2 cycles with pm_ack=1 -> pm_req=0, instr=0, instr_valid=0. After release, pm_req=1 and pm_addr=0 in the first cycle.
2. Straight-line fetch: mem[0..2]=E0A4,50A1,0000 with ack tied high -> instr_valid pulses in cycles 1,3,5 with instr_pc=0,1,2 and instr=E0A4,50A1,0000; instr=0 in between.
3. Two-word fetch: mem[3]=940C, mem[4]=0010 -> pm_addr 3 then 4, instr=940C, instr2=0010, instr_pc=3; next fetch at 5. Redirect to 0x0010 when consumed -> next pm_addr=0x0010.
4. Wait states and stall:
   - pm_ack delayed 3 cycles -> pm_addr/pm_req held, instr_valid=0.
   - stall=1 for 4 cycles during ISSUE -> instr unchanged and no new pm_req until stall drops.
5. Skip:
   - Consume at pc 6 with skip=1, mem[7]=9000 (LDS) -> addr 7 read and discarded, next fetch at 9, instr_pc=9.
   - Repeat with mem[7]=50A1 -> next fetch at 8.
6. Collisions:
   - Redirect to 0x0020 in the same cycle as pm_ack -> ack data dropped, pm_addr=0x0020, instr_valid=0.
   - Redirect with consume+skip -> no skip.
   - RST during FETCH2 -> full reset values.
   - PC wrap: RST_VEC=16'hFFFF -> fetches at FFFF then 0000.
